hnf_snp_ctl: RTL



---
 rtl/hnf_snp_ctl_pkg.sv | 51 +++++
 rtl/hnf_prio_enc.sv | 21 ++
 rtl/hnf_snp_ctl.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/hnf_snp_ctl_pkg.sv
// rtl/hnf_snp_ctl_pkg.sv - shared HN-F flit types, opcodes and cache-state encodings
package hnf_snp_ctl_pkg;

  localparam int numRNs            = 4;
  localparam int NODE_ID_W         = 7;
  localparam int TXN_ID_W          = 12;
  localparam int ADDR_W            = 44;
  localparam int REQ_OP_W          = 7;
  localparam int SNP_OP_W          = 5;
  localparam int RESP_W            = 3;
  localparam int CHI_CACHE_STATE_W = 2;

  localparam logic [REQ_OP_W-1:0] OP_ReadShared         = 7'h01;
  localparam logic [REQ_OP_W-1:0] OP_ReadClean          = 7'h02;
  localparam logic [REQ_OP_W-1:0] OP_ReadOnce           = 7'h03;
  localparam logic [REQ_OP_W-1:0] OP_ReadUnique         = 7'h07;
  localparam logic [REQ_OP_W-1:0] OP_CleanUnique        = 7'h0B;
  localparam logic [REQ_OP_W-1:0] OP_MakeUnique         = 7'h0C;
  localparam logic [REQ_OP_W-1:0] OP_ReadNotSharedDirty = 7'h26;

  localparam logic [SNP_OP_W-1:0] OP_SnpShared = 5'h01;
  localparam logic [SNP_OP_W-1:0] OP_SnpUnique = 5'h07;

  localparam logic [CHI_CACHE_STATE_W-1:0] ST_I  = 2'd0;
  localparam logic [CHI_CACHE_STATE_W-1:0] ST_SC = 2'd1;
  localparam logic [CHI_CACHE_STATE_W-1:0] ST_UC = 2'd2;
  localparam logic [CHI_CACHE_STATE_W-1:0] ST_UD = 2'd3;

  typedef enum logic [1:0] {IDLE, SEND, WAIT, DONE} snp_state_e;

  typedef struct packed {
    logic [REQ_OP_W-1:0]  Opcode;
    logic [NODE_ID_W-1:0] SrcID;
    logic [TXN_ID_W-1:0]  TxnID;
    logic [ADDR_W-1:0]    Addr;
  } reqflit_t;

  typedef struct packed {
    logic [SNP_OP_W-1:0]  Opcode;
    logic [NODE_ID_W-1:0] TgtID;
    logic [TXN_ID_W-1:0]  TxnID;
    logic [ADDR_W-1:0]    Addr;
  } snpflit_t;

  typedef struct packed {
    logic [NODE_ID_W-1:0] SrcID;
    logic [TXN_ID_W-1:0]  TxnID;
    logic [RESP_W-1:0]    Resp;
  } rspflit_t;

endpackage

// File: rtl/hnf_prio_enc.sv
// rtl/hnf_prio_enc.sv - lowest-set-bit priority encoder shared by HN-F arbiters
module hnf_prio_enc #(
  parameter int W     = 4,
  parameter int IDX_W = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]     vec,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Scanning downward lets the lowest set bit win the last assignment.
  always_comb begin
    idx = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (vec[i]) idx = IDX_W'(i);
    end
  end

  assign any = |vec;

endmodule

// File: rtl/hnf_snp_ctl.sv
// rtl/hnf_snp_ctl.sv - HN-F snoop controller: fans out snoops from an SF result and gathers responses
module hnf_snp_ctl
  import hnf_snp_ctl_pkg::*;
#(
  parameter int NUM_RN     = numRNs,
  parameter int RN_ID_BASE = 0,
  parameter int CNT_W      = $clog2(NUM_RN + 1)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  reqflit_t                     req,
  input  logic                         req_sf_hit,
  input  logic [NUM_RN-1:0]            req_sf_vec,
  input  logic [CHI_CACHE_STATE_W-1:0] req_sf_state,
  output logic                         snp_valid,
  input  logic                         snp_ready,
  output snpflit_t                     snp,
  input  logic                         snp_rsp_valid,
  input  rspflit_t                     snp_rsp,
  output logic                         done_valid,
  input  logic                         done_ready,
  output logic [TXN_ID_W-1:0]          done_txnid,
  output logic [NUM_RN-1:0]            done_vec,
  output logic                         done_pd
);

  localparam int IDX_W = (NUM_RN > 1) ? $clog2(NUM_RN) : 1;

  snp_state_e            state, state_nx;
  logic [NUM_RN-1:0]     tgt, tgt_left;
  logic [CNT_W-1:0]      cnt, cnt_nx;
  logic [TXN_ID_W-1:0]   txnid;
  logic [ADDR_W-1:0]     addr;
  logic [SNP_OP_W-1:0]   snp_op;
  logic [IDX_W-1:0]      idx;
  logic                  tgt_any;
  logic                  accept, snp_fire, rsp_ok, rsp_drop;
  logic [NUM_RN-1:0]     req_bit, acc_tgt, acc_vec;
  logic [SNP_OP_W-1:0]   acc_op;
  logic                  unused_rsp_bits;

  hnf_prio_enc #(.W(NUM_RN), .IDX_W(IDX_W)) u_prio (
    .vec (tgt),
    .idx (idx),
    .any (tgt_any)
  );

  assign req_ready  = (state == IDLE);
  assign snp_valid  = (state == SEND) && tgt_any;
  assign done_valid = (state == DONE);
  assign done_txnid = txnid;
  assign accept     = req_valid && req_ready;
  assign snp_fire   = snp_valid && snp_ready;
  assign rsp_ok     = snp_rsp_valid && ((state == SEND) || (state == WAIT)) &&
                      (snp_rsp.TxnID == txnid) && (cnt != '0);
  assign rsp_drop   = snp_rsp_valid && !rsp_ok;
  assign unused_rsp_bits = ^{snp_rsp.SrcID, snp_rsp.Resp[1:0]};

  assign snp.Opcode = snp_op;
  assign snp.TgtID  = NODE_ID_W'(RN_ID_BASE) + NODE_ID_W'(idx);
  assign snp.TxnID  = txnid;
  assign snp.Addr   = addr;

  // Requester bit stays clear when SrcID is not one of the tracked RN-Fs.
  always_comb begin
    req_bit = '0;
    for (int i = 0; i < NUM_RN; i++) begin
      if (int'(req.SrcID) == RN_ID_BASE + i) req_bit[i] = 1'b1;
    end
  end

  always_comb begin
    acc_tgt = '0;
    acc_op  = OP_SnpShared;
    acc_vec = req_sf_vec;
    if (req.Opcode == OP_ReadUnique || req.Opcode == OP_CleanUnique ||
        req.Opcode == OP_MakeUnique) begin
      acc_vec = req_bit;
      acc_op  = OP_SnpUnique;
      if (req_sf_hit) acc_tgt = req_sf_vec & ~req_bit;
    end else if (req.Opcode == OP_ReadShared || req.Opcode == OP_ReadClean ||
                 req.Opcode == OP_ReadNotSharedDirty) begin
      acc_vec = req_sf_vec | req_bit;
      if (req_sf_hit && (req_sf_state == ST_UC || req_sf_state == ST_UD))
        acc_tgt = req_sf_vec & ~req_bit;
    end
  end

  always_comb begin
    tgt_left      = tgt;
    tgt_left[idx] = 1'b0;
    cnt_nx        = cnt;
    if (snp_fire && !rsp_ok) cnt_nx = cnt + CNT_W'(1);
    else if (!snp_fire && rsp_ok) cnt_nx = cnt - CNT_W'(1);
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept) state_nx = (acc_tgt != '0) ? SEND : DONE;
      SEND: if (snp_fire && tgt_left == '0) state_nx = WAIT;
      WAIT: if (cnt_nx == '0) state_nx = DONE;
      DONE: if (done_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      tgt      <= '0;
      cnt      <= '0;
      txnid    <= '0;
      addr     <= '0;
      snp_op   <= OP_SnpShared;
      done_vec <= '0;
      done_pd  <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (accept) begin
        tgt      <= acc_tgt;
        txnid    <= req.TxnID;
        addr     <= req.Addr;
        snp_op   <= acc_op;
        done_vec <= acc_vec;
        done_pd  <= 1'b0;
      end else begin
        if (snp_fire) tgt <= tgt_left;
        if (rsp_ok) done_pd <= done_pd | snp_rsp.Resp[2];
      end
    end
  end

  // Stray responses are legal traffic to drop; record them as a coverage event.
  cover property (@(posedge clock) disable iff (!reset) rsp_drop);

endmodule
